// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns single write/read/poll commands into
// wen/ren strobes on the register bus and returns one response per command.
module reg_bus_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_MAX   = 16,
  parameter int POLL_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wen,
  output logic                  bus_ren,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [CNT_W-1:0] ATT_LAST = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  typedef enum logic [2:0] {IDLE, WR, RD, GAP, RESP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]        attempt_q, attempt_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic                    bus_wen_q, bus_wen_d;
  logic                    bus_ren_q, bus_ren_d;
  logic                    poll_match;

  // bus_wdata_q doubles as the expected poll value latched at accept
  assign poll_match = ((bus_rdata & mask_q) == (bus_wdata_q & mask_q));

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wen   = bus_wen_q;
  assign bus_ren   = bus_ren_q;

  // State and registered outputs; reset aborts any command in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      op_q        <= OP_WR;
      mask_q      <= '0;
      attempt_q   <= '0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wen_q   <= 1'b0;
      bus_ren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      attempt_q   <= attempt_d;
      gap_q       <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wen_q   <= bus_wen_d;
      bus_ren_q   <= bus_ren_d;
    end
  end

  // Next-state and next-output logic; strobes default low so each lasts one cycle
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mask_d      = mask_q;
    attempt_d   = attempt_q;
    gap_d       = gap_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wen_d   = 1'b0;
    bus_ren_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          mask_d      = cmd_mask;
          bus_addr_d  = cmd_addr;
          bus_wdata_d = cmd_wdata;
          attempt_d   = '0;
          case (cmd_op)
            OP_WR: begin
              state_d   = WR;
              bus_wen_d = 1'b1;
            end
            OP_RD: begin
              state_d   = RD;
              bus_ren_d = 1'b1;
            end
            OP_POLL: begin
              state_d   = RD;
              bus_ren_d = 1'b1;
              attempt_d = CNT_W'(1);
            end
            default: begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end
          endcase
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      RD: begin
        if (op_q == OP_POLL && !poll_match) begin
          if (attempt_q == ATT_LAST) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus_rdata;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_rdata;
          rsp_err_d   = 1'b0;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d   = RD;
          bus_ren_d = 1'b1;
          attempt_d = attempt_q + CNT_W'(1);
          gap_d     = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master with a small register responder.
module tb_reg_bus_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // responder / monitor state (written only by the monitor process)
  int          cyc = 0;
  int          ren_cnt = 0;
  int          wen_cnt = 0;
  int          ren_cyc[$];
  logic [31:0] reg0 = 32'h0;
  bit          both_hi = 1'b0;
  int          status_thr = 32'h7fffffff;

  reg_bus_master #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .POLL_MAX(16), .POLL_GAP(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // register 0x00 is read/write, 0x04 is a status whose bit0 rises after status_thr reads
  always_comb begin
    bus_rdata = 32'h0;
    if (bus_addr == 8'h00) bus_rdata = reg0;
    else if (bus_addr == 8'h04) bus_rdata = {31'h0, (ren_cnt >= status_thr)};
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_ren) begin
      ren_cnt <= ren_cnt + 1;
      ren_cyc.push_back(cyc);
    end
    if (bus_wen) begin
      wen_cnt <= wen_cnt + 1;
      if (bus_addr == 8'h00) reg0 <= bus_wdata;
    end
    if (bus_wen && bus_ren) both_hi <= 1'b1;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a,
                      input logic [31:0] wd, input logic [31:0] mk, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, bus_wen, bus_ren, rsp_rdata, bus_addr, bus_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b wen=%b ren=%b rdata=%h addr=%h wdata=%h want all 0",
               cmd_ready, rsp_valid, rsp_err, bus_wen, bus_ren, rsp_rdata, bus_addr, bus_wdata);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write;
    bit ok;
    int w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    send(2'b00, 8'h00, 32'h0000_00A5, 32'h0, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wr_accept: got no accept want accept"); end
    n_cmp++;
    if ({bus_wen, bus_ren, cmd_ready, rsp_valid} !== 4'b1000) begin
      n_bad++; $display("FAIL wr_strobe: got wen/ren/rdy/vld=%b want 1000", {bus_wen, bus_ren, cmd_ready, rsp_valid});
    end
    n_cmp++;
    if (bus_addr !== 8'h00 || bus_wdata !== 32'h0000_00A5) begin
      n_bad++; $display("FAIL wr_bus: got addr=%h wdata=%h want 00 000000a5", bus_addr, bus_wdata);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_wen, rsp_valid, rsp_err} !== 3'b010 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL wr_rsp: got wen=%b vld=%b err=%b rdata=%h want 0 1 0 0", bus_wen, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL wr_done: got vld=%b rdy=%b want 0 1", rsp_valid, cmd_ready);
    end
    n_cmp++;
    if (wen_cnt - w0 != 1 || ren_cnt - r0 != 0) begin
      n_bad++; $display("FAIL wr_counts: got wen=%0d ren=%0d want 1 0", wen_cnt - w0, ren_cnt - r0);
    end
  endtask

  task automatic test_read;
    bit ok;
    send(2'b01, 8'h00, 32'h0, 32'h0, ok);
    n_cmp++;
    if (!ok || bus_ren !== 1'b1 || bus_wen !== 1'b0) begin
      n_bad++; $display("FAIL rd_strobe: got ok=%b ren=%b wen=%b want 1 1 0", ok, bus_ren, bus_wen);
    end
    @(negedge clk);
    n_cmp++;
    if (bus_ren !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00A5 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL rd_data: got ren=%b vld=%b rdata=%h err=%b want 0 1 000000a5 0", bus_ren, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
    send(2'b01, 8'h08, 32'h0, 32'h0, ok);
    @(negedge clk);
    n_cmp++;
    if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL rd_unmapped: got ok=%b vld=%b rdata=%h err=%b want 1 1 0 0", ok, rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_poll_ok;
    bit ok, sp_bad;
    int r0, q0;
    r0 = ren_cnt; q0 = ren_cyc.size(); sp_bad = 1'b0;
    status_thr = ren_cnt + 2;
    send(2'b10, 8'h04, 32'h1, 32'h1, ok);
    wait_rsp(100, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL poll_ok_rsp: got no response want response"); end
    n_cmp++;
    if (ren_cnt - r0 != 3) begin n_bad++; $display("FAIL poll_ok_pulses: got %0d want 3", ren_cnt - r0); end
    for (int i = 1; i < 3; i++)
      if (ren_cyc.size() > q0 + i && ren_cyc[q0+i] - ren_cyc[q0+i-1] != 5) sp_bad = 1'b1;
    n_cmp++;
    if (sp_bad) begin n_bad++; $display("FAIL poll_ok_spacing: got uneven spacing want 5 cycles"); end
    n_cmp++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h1) begin
      n_bad++; $display("FAIL poll_ok_data: got err=%b rdata=%h want 0 00000001", rsp_err, rsp_rdata);
    end
    @(negedge clk);
    status_thr = 32'h7fffffff;
  endtask

  task automatic test_poll_timeout;
    bit ok, sp_bad;
    int r0, q0;
    r0 = ren_cnt; q0 = ren_cyc.size(); sp_bad = 1'b0;
    status_thr = 32'h7fffffff;
    send(2'b10, 8'h04, 32'h1, 32'h1, ok);
    wait_rsp(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL poll_to_rsp: got no response want response"); end
    n_cmp++;
    if (ren_cnt - r0 != 16) begin n_bad++; $display("FAIL poll_to_pulses: got %0d want 16", ren_cnt - r0); end
    for (int i = 1; i < 16; i++)
      if (ren_cyc.size() > q0 + i && ren_cyc[q0+i] - ren_cyc[q0+i-1] != 5) sp_bad = 1'b1;
    n_cmp++;
    if (sp_bad) begin n_bad++; $display("FAIL poll_to_spacing: got uneven spacing want 5 cycles"); end
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL poll_to_data: got err=%b rdata=%h want 1 00000000", rsp_err, rsp_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_poll_mask0;
    bit ok;
    int r0;
    r0 = ren_cnt;
    send(2'b10, 8'h04, 32'h1, 32'h0, ok);
    wait_rsp(100, ok);
    n_cmp++;
    if (!ok || ren_cnt - r0 != 1 || rsp_err !== 1'b0) begin
      n_bad++; $display("FAIL poll_mask0: got ok=%b pulses=%0d err=%b want 1 1 0", ok, ren_cnt - r0, rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    bit ok, unstable;
    int w0;
    unstable = 1'b0;
    rsp_ready = 1'b0;
    send(2'b01, 8'h00, 32'h0, 32'h0, ok);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 8'h00; cmd_wdata = 32'h0000_005A; cmd_mask = 32'h0;
    w0 = wen_cnt;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0000_00A5 || cmd_ready !== 1'b0) unstable = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (unstable) begin n_bad++; $display("FAIL bp_hold: got response/ready changed want vld=1 rdata=000000a5 rdy=0"); end
    n_cmp++;
    if (wen_cnt != w0) begin n_bad++; $display("FAIL bp_early_accept: got %0d writes want 0", wen_cnt - w0); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || bus_wen !== 1'b0) begin
      n_bad++; $display("FAIL bp_handshake: got vld=%b rdy=%b wen=%b want 0 1 0", rsp_valid, cmd_ready, bus_wen);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (bus_wen !== 1'b1 || bus_wdata !== 32'h0000_005A) begin
      n_bad++; $display("FAIL bp_next_cmd: got wen=%b wdata=%h want 1 0000005a", bus_wen, bus_wdata);
    end
    wait_rsp(20, ok);
    @(negedge clk);
  endtask

  task automatic test_illegal;
    bit ok;
    int w0, r0;
    w0 = wen_cnt; r0 = ren_cnt;
    send(2'b11, 8'h10, 32'h1234, 32'h0, ok);
    n_cmp++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL illegal_rsp: got ok=%b vld=%b err=%b rdata=%h want 1 1 1 0", ok, rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (wen_cnt != w0 || ren_cnt != r0) begin
      n_bad++; $display("FAIL illegal_strobes: got wen=%0d ren=%0d want 0 0", wen_cnt - w0, ren_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_poll;
    bit ok, saw_vld;
    int r0;
    saw_vld = 1'b0;
    status_thr = 32'h7fffffff;
    send(2'b10, 8'h04, 32'h1, 32'h1, ok);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cmd_ready, rsp_valid, rsp_err, bus_wen, bus_ren, rsp_rdata, bus_addr, bus_wdata} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b err=%b wen=%b ren=%b rdata=%h addr=%h wdata=%h want all 0",
               cmd_ready, rsp_valid, rsp_err, bus_wen, bus_ren, rsp_rdata, bus_addr, bus_wdata);
    end
    r0 = ren_cnt;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL midreset_ready_low: got %b want 0", cmd_ready); end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", cmd_ready); end
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) saw_vld = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (ren_cnt != r0 || saw_vld) begin
      n_bad++; $display("FAIL midreset_quiet: got ren=%0d vld_seen=%b want 0 0", ren_cnt - r0, saw_vld);
    end
  endtask

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h0; cmd_wdata = 32'h0; cmd_mask = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_poll_ok();
    test_poll_timeout();
    test_poll_mask0();
    test_back_to_back();
    test_illegal();
    test_reset_mid_poll();
    n_cmp++;
    if (both_hi) begin n_bad++; $display("FAIL strobe_overlap: got wen&ren high together want never"); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
